sram_arbiter: RTL
=================

Name: sram_arbiter

Overview:
- Shares the single external pixel SRAM between three clients:
  - the VGA display adapter's scan-out read port, which has absolute priority;
  - a buffered write port used by the character renderer;
  - a single-outstanding read port for renderer read-back (scroll/copy).
- Display requests pass through in the same cycle. Renderer traffic fills every cycle the display leaves free.
- Sits between the display adapter, the renderer and the top-level SRAM pad driver.

Parameters:
- ADDR_W, 20, SRAM word-address width
- DATA_W, 32, SRAM word width (one pixel pair)
- WR_FIFO_DEPTH, 4, write-buffer entries (power of two, >=2)
- STALL_W, 16, width of the saturating stall counter

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- dispRequest  in  SramRequest_t  display request; only address and oe_n are used
- dispResult  out  SramResult_t  read data returned to the display
- wrValid  in  1  renderer write request valid
- wrReady  out  1  write buffer can accept an entry
- wrAddress  in  ADDR_W  write word address
- wrData  in  DATA_W  write data
- rdValid  in  1  renderer read request valid
- rdReady  out  1  no renderer read is pending
- rdAddress  in  ADDR_W  read word address
- rdDataValid  out  1  one-cycle pulse: rdData is valid
- rdData  out  DATA_W  renderer read data
- sramRequest  out  SramRequest_t  to the SRAM pad driver
- sramWriteData  out  DATA_W  data driven onto the bus while den=1
- sramResult  in  SramResult_t  data from the SRAM bus
- idle  out  1  write FIFO empty and no read pending
- stallCount  out  STALL_W  saturating count of cycles in which renderer work was blocked by the display

Behaviour:
- Clock and reset: one clock, `clk`. Reset `rst` is synchronous and active-high. Every SRAM operation completes in a single cycle.

- Bus mux (combinational), evaluated in priority order:
  1. If dispRequest.oe_n==0: sramRequest = {address=dispRequest.address, oe_n=0, we_n=1, den=0}. dispRequest.we_n and dispRequest.den are ignored; the display is read-only.
  2. Else if a write is granted: {FIFO head address, oe_n=1, we_n=0, den=1}, with sramWriteData = FIFO head data. The FIFO pops at the end of the cycle.
  3. Else if a read is granted: {pending read address, oe_n=0, we_n=1, den=0}.
  4. Else: idle bus, oe_n=1, we_n=1, den=0, address=0.
- dispResult = sramResult at all times (combinational), so display latency is 0 cycles.

- Low-priority grant:
  - When both the FIFO is non-empty and a read is pending, use round-robin. The lastGrant flop records the last granted client; the other one wins.
  - When only one client has work, it is granted.
  - lastGrant updates only on an actual grant, never in a cycle the display owns the bus.

- Write port:
  - Entry is accepted when wrValid && wrReady.
  - wrReady = (count < WR_FIFO_DEPTH), registered count only. There is no same-cycle bypass: a full FIFO that pops this cycle still shows wrReady=0.
  - An accepted entry is eligible for grant no earlier than the next cycle.
  - Writes retire in FIFO order.

- Read port:
  - wrReady-style handshake: rdReady = !rdPending. A request is accepted when rdValid && rdReady.
  - Address is latched at acceptance; the request is eligible for grant the next cycle.
  - In the grant cycle, sramResult is registered into rdData.
  - rdDataValid pulses in the cycle after the grant, and rdPending clears in that same cycle.
  - Minimum latency from acceptance to rdDataValid is 2 cycles.
  - A new request may be accepted in the same cycle rdDataValid is high.

- stallCount:
  - Increments when (FIFO non-empty || rdPending) && dispRequest.oe_n==0.
  - Saturates at all-ones and never wraps.

- idle = FIFO empty && !rdPending (registered state).

- Reset, including mid-operation:
  - FIFO emptied, so wrReady=1.
  - rdPending=0, rdReady=1, rdDataValid=0, rdData=0.
  - lastGrant=read, so the first tie goes to the write.
  - stallCount=0, idle=1.
  - Any in-flight write or read is dropped.

Decomposition:
- Shared DataType package: SramRequest_t / SramResult_t (already present), plus ADDR_W/DATA_W constants and the ArbGrant_t enum {GRANT_NONE, GRANT_DISP, GRANT_WRITE, GRANT_READ}.
- One sub-module, sram_write_fifo: synchronous FIFO with WR_FIFO_DEPTH entries of {address, data} and push/pop/count/empty/full ports.

Test Plan:
- Write with display idle: wrValid for 1 cycle, address 0x00010, data 0xDEADBEEF -> next cycle we_n=0, den=1, address 0x00010, sramWriteData 0xDEADBEEF; idle returns to 1 the following cycle.
- Display pre-emption: FIFO holds 1 write; dispRequest.oe_n=0 for 3 cycles -> bus shows the display address each cycle; write issues in the 4th cycle; stallCount=3.
- FIFO full: push 4 entries while the display holds the bus -> wrReady=0 after the 4th; 5th wrValid not accepted; release the display -> writes retire in push order, wrReady=1 one cycle after the first pop.
- Round-robin tie: FIFO and read pending simultaneously after reset -> write granted first, then read; rdData = sramResult captured in the grant cycle; rdDataValid pulses exactly 1 cycle later.
- Reset mid-operation: assert rst with 2 writes queued and a read pending -> next cycle wrReady=1, rdReady=1, idle=1, stallCount=0, bus idle, no further writes issued.
- Display interleave: display reads every other cycle for 800 cycles with writes continuously queued -> every free cycle carries a write, and no cycle ever has oe_n=0 together with we_n=0.

Source files
------------

// File: rtl/sram_arbiter_pkg.sv
// Shared types for the pixel SRAM arbiter: SRAM bus request/result records,
// write-buffer entry and the grant encoding.
package sram_arbiter_pkg;

  localparam int ADDR_W = 20;
  localparam int DATA_W = 32;

  typedef struct packed {
    logic [ADDR_W-1:0] address;
    logic              oe_n;
    logic              we_n;
    logic              den;
  } SramRequest_t;

  typedef struct packed {
    logic [DATA_W-1:0] data;
  } SramResult_t;

  typedef struct packed {
    logic [ADDR_W-1:0] address;
    logic [DATA_W-1:0] data;
  } WrEntry_t;

  typedef enum logic [1:0] {
    GRANT_NONE,
    GRANT_DISP,
    GRANT_WRITE,
    GRANT_READ
  } ArbGrant_t;

endpackage

// File: rtl/sram_arbiter_if.sv
// Client/SRAM-side signal bundle of the arbiter. The slave modport is the
// arbiter's view; master is the view of everything around it.
interface sram_arbiter_if #(
  parameter int STALL_W = 16
);
  import sram_arbiter_pkg::*;

  SramRequest_t      dispRequest;
  SramResult_t       dispResult;
  logic              wrValid;
  logic              wrReady;
  logic [ADDR_W-1:0] wrAddress;
  logic [DATA_W-1:0] wrData;
  logic              rdValid;
  logic              rdReady;
  logic [ADDR_W-1:0] rdAddress;
  logic              rdDataValid;
  logic [DATA_W-1:0] rdData;
  SramRequest_t      sramRequest;
  logic [DATA_W-1:0] sramWriteData;
  SramResult_t       sramResult;
  logic              idle;
  logic [STALL_W-1:0] stallCount;

  modport slave (
    input  dispRequest, wrValid, wrAddress, wrData, rdValid, rdAddress, sramResult,
    output dispResult, wrReady, rdReady, rdDataValid, rdData, sramRequest,
    output sramWriteData, idle, stallCount
  );

  modport master (
    output dispRequest, wrValid, wrAddress, wrData, rdValid, rdAddress, sramResult,
    input  dispResult, wrReady, rdReady, rdDataValid, rdData, sramRequest,
    input  sramWriteData, idle, stallCount
  );

endinterface

// File: rtl/sram_write_fifo.sv
// Small synchronous FIFO of {address, data} write entries. The head entry is
// readable combinationally so it can be placed on the bus in its grant cycle.
module sram_write_fifo
  import sram_arbiter_pkg::*;
#(
  parameter  int DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH)
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           push_i,
  input  WrEntry_t       push_entry_i,
  input  logic           pop_i,
  output WrEntry_t       head_o,
  output logic [PTR_W:0] count_o,
  output logic           empty_o,
  output logic           full_o
);

  WrEntry_t         mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [PTR_W:0]   count_q;
  logic             do_push;
  logic             do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (PTR_W+1)'(DEPTH));
  assign count_o = count_q;
  assign head_o  = mem_q[rd_ptr_q];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem_q[wr_ptr_q] <= push_entry_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (PTR_W+1)'(1);
        2'b01:   count_q <= count_q - (PTR_W+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/sram_arbiter.sv
// Pixel SRAM arbiter: display scan-out owns the bus whenever it asks; buffered
// renderer writes and single-outstanding renderer reads share the rest.
module sram_arbiter
  import sram_arbiter_pkg::*;
#(
  parameter int WR_FIFO_DEPTH = 4,
  parameter int STALL_W       = 16
) (
  input logic           clk,
  input logic           rst,
  sram_arbiter_if.slave bus
);

  localparam int CNT_W = $clog2(WR_FIFO_DEPTH) + 1;

  WrEntry_t          push_entry;
  WrEntry_t          fifo_head;
  logic [CNT_W-1:0]  fifo_count;
  logic              fifo_empty;
  logic              fifo_full;
  logic              wr_push;
  logic              wr_pop;
  logic              disp_active;
  logic              rd_accept;
  ArbGrant_t         grant;
  ArbGrant_t         last_grant_q;
  logic              rd_pending_q;
  logic [ADDR_W-1:0] rd_addr_q;
  logic              rd_valid_q;
  logic [DATA_W-1:0] rd_data_q;
  logic [STALL_W-1:0] stall_q;
  SramRequest_t      sram_req;
  logic [DATA_W-1:0] sram_wdata;

  assign push_entry  = '{address: bus.wrAddress, data: bus.wrData};
  assign wr_push     = bus.wrValid && !fifo_full;
  assign wr_pop      = (grant == GRANT_WRITE);
  assign disp_active = !bus.dispRequest.oe_n;
  assign rd_accept   = bus.rdValid && !rd_pending_q;

  sram_write_fifo #(
    .DEPTH(WR_FIFO_DEPTH)
  ) u_write_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (wr_push),
    .push_entry_i(push_entry),
    .pop_i       (wr_pop),
    .head_o      (fifo_head),
    .count_o     (fifo_count),
    .empty_o     (fifo_empty),
    .full_o      (fifo_full)
  );

  // Renderer clients alternate on a tie; lastGrant names the loser of the next tie.
  always_comb begin
    grant = GRANT_NONE;
    if (disp_active) begin
      grant = GRANT_DISP;
    end else if (!fifo_empty && rd_pending_q) begin
      grant = (last_grant_q == GRANT_READ) ? GRANT_WRITE : GRANT_READ;
    end else if (!fifo_empty) begin
      grant = GRANT_WRITE;
    end else if (rd_pending_q) begin
      grant = GRANT_READ;
    end
  end

  always_comb begin
    sram_req   = '{address: '0, oe_n: 1'b1, we_n: 1'b1, den: 1'b0};
    sram_wdata = '0;
    case (grant)
      GRANT_DISP: begin
        sram_req.address = bus.dispRequest.address;
        sram_req.oe_n    = 1'b0;
      end
      GRANT_WRITE: begin
        sram_req.address = fifo_head.address;
        sram_req.we_n    = 1'b0;
        sram_req.den     = 1'b1;
        sram_wdata       = fifo_head.data;
      end
      GRANT_READ: begin
        sram_req.address = rd_addr_q;
        sram_req.oe_n    = 1'b0;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last_grant_q <= GRANT_READ;
      rd_pending_q <= 1'b0;
      rd_addr_q    <= '0;
      rd_valid_q   <= 1'b0;
      rd_data_q    <= '0;
      stall_q      <= '0;
    end else begin
      rd_valid_q <= (grant == GRANT_READ);
      if (grant == GRANT_READ) begin
        rd_data_q    <= bus.sramResult.data;
        rd_pending_q <= 1'b0;
      end else if (rd_accept) begin
        rd_addr_q    <= bus.rdAddress;
        rd_pending_q <= 1'b1;
      end
      if (grant == GRANT_WRITE || grant == GRANT_READ) begin
        last_grant_q <= grant;
      end
      if ((!fifo_empty || rd_pending_q) && disp_active && stall_q != {STALL_W{1'b1}}) begin
        stall_q <= stall_q + STALL_W'(1);
      end
    end
  end

  assign bus.sramRequest   = sram_req;
  assign bus.sramWriteData = sram_wdata;
  assign bus.dispResult    = bus.sramResult;
  assign bus.wrReady       = (fifo_count < CNT_W'(WR_FIFO_DEPTH));
  assign bus.rdReady       = !rd_pending_q;
  assign bus.rdDataValid   = rd_valid_q;
  assign bus.rdData        = rd_data_q;
  assign bus.idle          = fifo_empty && !rd_pending_q;
  assign bus.stallCount    = stall_q;

endmodule
